// File: rtl/pb_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pb_event_decoder
//  Description : Turns a debounced pushbutton level into single-cycle user
//                events: press, release, single click, double click,
//                long press and auto-repeat, plus a "held" level.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   system clock, all logic on posedge
//    rst_n         in   synchronous active-low reset
//    pb_debounced  in   debounced button level, 1 = pressed
//    press_pulse   out  one-cycle pulse on detected press
//    release_pulse out  one-cycle pulse on detected release
//    single_click  out  one-cycle pulse, short press with no second press
//    double_click  out  one-cycle pulse, second press inside the window
//    long_press    out  one-cycle pulse after LONG_CYCLES held
//    repeat_pulse  out  one-cycle pulse every REPEAT_CYCLES after long_press
//    held          out  level, high while in any pressed state
// ============================================================================
module pb_event_decoder #(
    parameter int LONG_CYCLES   = 200,
    parameter int REPEAT_CYCLES = 50,
    parameter int DCLICK_CYCLES = 60,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESSED      = 3'd1,
        ST_LONG_HELD    = 3'd2,
        ST_WAIT_SECOND  = 3'd3,
        ST_SECOND_PRESS = 3'd4
    } state_t;

    // The counter is cleared on the edge that enters a timed state, so at
    // edge entry+k it still holds k-1; a threshold of N therefore fires when
    // the counter reads N-1.
    localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pb_d_q;
    logic             press_q,  press_d;
    logic             release_q, release_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q,   long_d;
    logic             repeat_q, repeat_d;
    logic             held_q,   held_d;

    logic             w_rise;
    logic             w_fall;

    assign w_rise = pb_debounced & ~pb_d_q;
    assign w_fall = ~pb_debounced & pb_d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // In every timed state the counter is cleared as soon as it hits its
        // threshold, so the increment branch never runs past it and cannot wrap.
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // Release is checked first so it beats a coincident long press.
                if (w_fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_SECOND;
                end else if (cnt_q == c_long_last) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LONG_HELD;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == c_repeat_last) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_WAIT_SECOND: begin
                // A press on the closing edge of the window still counts.
                if (w_rise) begin
                    press_d  = 1'b1;
                    double_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SECOND_PRESS;
                end else if (cnt_q == c_dclick_last) begin
                    single_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_SECOND_PRESS: begin
                if (w_fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) ||
                 (state_d == ST_SECOND_PRESS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pb_d_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pb_d_q    <= pb_debounced;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_event_decoder
//  Description : Self-checking bench for pb_event_decoder. A timestamp-based
//                reference model queues the expected output events; a
//                separate monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_event_decoder;

    localparam int LONG_C   = 200;
    localparam int REPEAT_C = 50;
    localparam int DCLICK_C = 60;

    logic clk = 1'b0;
    logic rst_n;
    logic pb;
    logic press_pulse, release_pulse, single_click, double_click;
    logic long_press, repeat_pulse, held;

    pb_event_decoder #(
        .LONG_CYCLES   (LONG_C),
        .REPEAT_CYCLES (REPEAT_C),
        .DCLICK_CYCLES (DCLICK_C),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_debounced  (pb),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .single_click  (single_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // Output vector layout: {held, press, release, single, double, long, repeat}
    typedef struct packed {
        int unsigned tag;
        logic [6:0]  vec;
    } exp_t;

    exp_t        q[$];
    int unsigned edge_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // ---------------- reference model (timestamps, not a counter FSM) -------
    bit          m_down, m_long, m_second, m_window, m_held;
    int unsigned m_t_press, m_t_release;

    function automatic void model_edge(input int unsigned n, input logic pbv, input logic rstv);
        logic [5:0]  ev;
        logic        held_before;
        int unsigned age;
        ev          = '0;
        held_before = m_held;
        if (!rstv) begin
            m_down   = 1'b0;
            m_long   = 1'b0;
            m_second = 1'b0;
            m_window = 1'b0;
        end else if (m_down) begin
            age = n - m_t_press;
            if (!pbv) begin
                ev[4]  = 1'b1;
                m_down = 1'b0;
                if (!m_long && !m_second) begin
                    m_window    = 1'b1;
                    m_t_release = n;
                end
            end else if (!m_second) begin
                if (age == LONG_C) begin
                    ev[1]  = 1'b1;
                    m_long = 1'b1;
                end else if (m_long && ((age - LONG_C) % REPEAT_C) == 0) begin
                    ev[0] = 1'b1;
                end
            end
        end else if (pbv) begin
            ev[5]     = 1'b1;
            m_down    = 1'b1;
            m_t_press = n;
            m_long    = 1'b0;
            m_second  = m_window && ((n - m_t_release) <= DCLICK_C);
            if (m_second) ev[2] = 1'b1;
            m_window  = 1'b0;
        end else if (m_window && (n - m_t_release) == DCLICK_C) begin
            ev[3]    = 1'b1;
            m_window = 1'b0;
        end
        m_held = m_down;
        if (ev != 6'd0 || m_held != held_before)
            q.push_back('{tag: n, vec: {m_held, ev}});
    endfunction

    // ---------------- stimulus ----------------------------------------------
    task automatic step(input logic pbv, input logic rstv);
        pb    = pbv;
        rst_n = rstv;
        model_edge(edge_cnt + 1, pbv, rstv);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input logic pbv, input int n);
        for (int i = 0; i < n; i++) step(pbv, 1'b1);
    endtask

    // ---------------- monitor -----------------------------------------------
    logic held_prev = 1'b0;

    always @(negedge clk) begin
        logic [6:0] got;
        exp_t       e;
        got = {held, press_pulse, release_pulse, single_click, double_click,
               long_press, repeat_pulse};
        while (q.size() > 0 && q[0].tag < edge_cnt) begin
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_event edge=%0d expected=%b got_nothing", e.tag, e.vec);
        end
        if (got[5:0] != 6'd0 || got[6] !== held_prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event edge=%0d got=%b expected=none", edge_cnt, got);
            end else begin
                e = q.pop_front();
                if (e.tag != edge_cnt || e.vec !== got) begin
                    n_err++;
                    $display("FAIL event edge=%0d got=%b expected edge=%0d vec=%b",
                             edge_cnt, got, e.tag, e.vec);
                end
            end
        end
        held_prev = got[6];
    end

    // ---------------- test sequence -----------------------------------------
    initial begin
        logic pb_lvl;
        int   len;
        int   kind;

        pb    = 1'b0;
        rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0);

        // idle after reset: nothing must happen
        hold(1'b0, 500);
        // single click
        hold(1'b1, 10);  hold(1'b0, 80);
        // double click, re-press 30 cycles after release
        hold(1'b1, 10);  hold(1'b0, 30);  hold(1'b1, 5);  hold(1'b0, 80);
        // long press with repeats
        hold(1'b1, 320); hold(1'b0, 80);
        // release on the long-press edge
        hold(1'b1, 200); hold(1'b0, 80);
        // second press on the last window edge
        hold(1'b1, 10);  hold(1'b0, 60);  hold(1'b1, 5);  hold(1'b0, 80);
        // second press one past the window
        hold(1'b1, 10);  hold(1'b0, 61);  hold(1'b1, 5);  hold(1'b0, 80);
        // reset during LONG_HELD with the button still down
        hold(1'b1, 250);
        repeat (3) step(1'b1, 1'b0);
        hold(1'b1, 210); hold(1'b0, 80);
        // back-to-back toggles
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1);
        hold(1'b0, 80);

        // randomized runs
        pb_lvl = 1'b0;
        for (int r = 0; r < 150; r++) begin
            kind   = int'($urandom_range(0, 19));
            pb_lvl = ~pb_lvl;
            if (kind < 8)       len = int'($urandom_range(1, 12));
            else if (kind < 14) len = int'($urandom_range(55, 66));
            else if (kind < 19) len = int'($urandom_range(190, 330));
            else begin
                len = int'($urandom_range(1, 3));
                for (int i = 0; i < len; i++) step(pb_lvl, 1'b0);
                len = 1;
            end
            hold(pb_lvl, len);
        end
        hold(1'b0, 120);
        #1;

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_events count=%0d expected=0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
